// File: rtl/pc_pkg.sv
// Shared types, defaults and the alignment helper for the program-counter generator.
package pc_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int          INC_DEF          = 4;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_t;

    // Addresses are widened to 64 bits so one helper serves every XLEN up to 64.
    function automatic logic is_aligned(input logic [63:0] addr, input int align_bits);
        logic [63:0] mask;
        mask = (64'd1 << align_bits) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push when full overwrites the oldest entry.
// Single-cycle update, top is combinational from the pointer; no backpressure.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int              PW      = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = 1;
    localparam logic [PW:0]     CNT_ONE = 1;
    localparam logic [PW:0]     CNT_MAX = RAS_DEPTH[PW:0];

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [PW:0]     cnt;

    assign top_idx = ptr - PTR_ONE;
    assign top     = mem[top_idx];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (clear) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_ONE;
            if (!full) cnt <= cnt + CNT_ONE;
        end else if (pop && !empty) begin
            ptr <= top_idx;
            cnt <= cnt - CNT_ONE;
        end
    end

    // Entries are only read while the count says they are valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential advance, redirects, traps and RAS return prediction.
// pc is registered, one cycle after the triggering edge; pc held while pc_ready is low.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int              INC          = INC_DEF,
    parameter int              ALIGN_BITS   = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            call_hint,
    input  logic            ret_hint,
    output logic            fault,
    output logic            ras_miss
);

    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_nxt, pc_seq, ras_top;
    logic            fault_nxt, miss_nxt, fire;
    logic            ras_push, ras_pop, ras_clear, ras_empty;

    assign pc_valid = (state == RUN);
    assign fire     = pc_valid & pc_ready;
    assign pc_seq   = pc + INC_V;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        fault_nxt = fault;
        miss_nxt  = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        if (trap_valid) begin
            pc_nxt    = trap_vec;
            state_nxt = RUN;
            fault_nxt = 1'b0;
            ras_clear = 1'b1;
        end else if (state == BOOT) begin
            state_nxt = RUN;
        end else if (state == RUN) begin
            if (redirect_valid) begin
                if (is_aligned(64'(redirect_pc), ALIGN_BITS)) begin
                    pc_nxt = redirect_pc;
                end else begin
                    state_nxt = HALT;
                    fault_nxt = 1'b1;
                end
            end else if (fire) begin
                // Return wins over call when both hints are set, and never pushes.
                if (ret_hint) begin
                    if (!ras_empty) begin
                        pc_nxt  = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        pc_nxt   = pc_seq;
                        miss_nxt = 1'b1;
                    end
                end else begin
                    pc_nxt   = pc_seq;
                    ras_push = call_hint;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            fault    <= 1'b0;
            ras_miss <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            fault    <= fault_nxt;
            ras_miss <= miss_nxt;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized bench for pc_gen against a queue-based reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid, pc_ready;
    logic        redirect_valid, trap_valid, call_hint, ret_hint;
    logic [31:0] redirect_pc, trap_vec;
    logic        fault, ras_miss;

    int errors = 0;
    int checks = 0;

    // Reference model: 0=boot, 1=run, 2=halt; RAS as a bounded queue (back = top).
    int          m_state;
    logic [31:0] m_pc;
    logic        m_fault, m_miss;
    logic [31:0] ras[$];

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .ALIGN_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_vec(trap_vec),
        .call_hint(call_hint), .ret_hint(ret_hint),
        .fault(fault), .ras_miss(ras_miss)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h0;
        m_fault = 1'b0;
        m_miss  = 1'b0;
        ras.delete();
    endtask

    task automatic model_edge();
        logic fire;
        fire   = (m_state == 1) && pc_ready;
        m_miss = 1'b0;
        if (trap_valid) begin
            m_pc = trap_vec; m_state = 1; m_fault = 1'b0; ras.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (redirect_valid) begin
                if (redirect_pc[1:0] == 2'b00) m_pc = redirect_pc;
                else begin m_state = 2; m_fault = 1'b1; end
            end else if (fire) begin
                if (ret_hint) begin
                    if (ras.size() > 0) m_pc = ras.pop_back();
                    else begin m_pc = m_pc + 32'd4; m_miss = 1'b1; end
                end else begin
                    if (call_hint) begin
                        ras.push_back(m_pc + 32'd4);
                        if (ras.size() > 4) void'(ras.pop_front());
                    end
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("pc_valid", 32'(pc_valid), 32'(m_state == 1));
        check("fault", 32'(fault), 32'(m_fault));
        check("ras_miss", 32'(ras_miss), 32'(m_miss));
    endtask

    // Inputs are set at the falling edge; step returns at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        redirect_valid = 0; trap_valid = 0; call_hint = 0; ret_hint = 0; pc_ready = rdy;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        idle(1'b0); redirect_valid = 1; redirect_pc = target; step();
        redirect_valid = 0;
    endtask

    task automatic do_trap(input logic [31:0] vec);
        idle(1'b0); trap_valid = 1; trap_vec = vec; step();
        trap_valid = 0;
    endtask

    initial begin
        rst = 1'b0; redirect_pc = '0; trap_vec = '0;
        idle(1'b1);
        model_reset();
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(pc_valid), 32'h0);
        repeat (2) @(negedge clk);
        check("rst_hold_valid", 32'(pc_valid), 32'h0);
        rst = 1'b1;

        // Boot then sequential fetch.
        step(); check("boot_valid", 32'(pc_valid), 32'h1); check("boot_pc", pc, 32'h0);
        step(); check("seq_pc4", pc, 32'h4);
        step(); check("seq_pc8", pc, 32'h8);

        // Stall, then redirect while stalled.
        do_redirect(32'h10);
        idle(1'b0);
        repeat (3) step();
        check("stall_pc", pc, 32'h10);
        do_redirect(32'h200);
        check("redir_pc", pc, 32'h200);

        // Misaligned redirect halts; redirects ignored in halt; trap recovers.
        do_redirect(32'h202);
        check("mis_valid", 32'(pc_valid), 32'h0);
        check("mis_fault", 32'(fault), 32'h1);
        check("mis_pc", pc, 32'h200);
        do_redirect(32'h100);
        check("halt_ignore_pc", pc, 32'h200);
        do_trap(32'h80);
        check("trap_pc", pc, 32'h80);
        check("trap_fault", 32'(fault), 32'h0);
        check("trap_valid", 32'(pc_valid), 32'h1);

        // RAS overflow: five calls, four good returns, then a miss.
        do_trap(32'h0);
        idle(1'b1); call_hint = 1;
        repeat (5) step();
        check("calls_pc", pc, 32'h14);
        idle(1'b1); ret_hint = 1;
        step(); check("ret1", pc, 32'h14);
        step(); check("ret2", pc, 32'h10);
        step(); check("ret3", pc, 32'hC);
        step(); check("ret4", pc, 32'h8);
        step(); check("ret_miss_pc", pc, 32'hC); check("ret_miss", 32'(ras_miss), 32'h1);
        idle(1'b0);
        step(); check("miss_pulse_end", 32'(ras_miss), 32'h0);

        // Both hints: return wins and nothing is pushed.
        idle(1'b1); call_hint = 1; ret_hint = 1;
        step(); check("both_hint_pc", pc, 32'h10);
        idle(1'b1); ret_hint = 1;
        step(); check("both_no_push", 32'(ras_miss), 32'h1);

        // Wrap-around and trap-over-redirect priority.
        do_redirect(32'hFFFF_FFFC);
        idle(1'b1);
        step(); check("wrap_pc", pc, 32'h0);
        idle(1'b1); trap_valid = 1; trap_vec = 32'h40; redirect_valid = 1; redirect_pc = 32'h300;
        step(); check("prio_pc", pc, 32'h40);

        // Asynchronous reset between edges.
        idle(1'b1);
        step(); step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_pc", pc, 32'h0);
        check("arst_valid", 32'(pc_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            trap_valid     = ($urandom_range(0, 24) == 0);
            trap_vec       = {$urandom_range(0, 1023), 2'b00};
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4095))
                                                         : {$urandom_range(0, 1023), 2'b00};
            pc_ready       = ($urandom_range(0, 3) != 0);
            call_hint      = ($urandom_range(0, 3) == 0);
            ret_hint       = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
